// File: rtl/axil_dma_pkg.sv
// Shared register map, field positions and response codes for the DMA descriptor queue.
package axil_dma_pkg;

    localparam logic [3:0]  OFF_ADDR        = 4'h0;
    localparam logic [3:0]  OFF_LEN         = 4'h4;
    localparam logic [3:0]  OFF_CTRL        = 4'h8;
    localparam logic [3:0]  OFF_STATUS      = 4'hC;
    localparam logic [31:0] ADDR_MAC_CONFIG = 32'h100;
    localparam logic [31:0] ADDR_INFO       = 32'h104;

    localparam int CTRL_PUSH_BIT  = 0;
    localparam int CTRL_FLUSH_BIT = 1;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        SEL_NONE, SEL_ADDR, SEL_LEN, SEL_CTRL, SEL_STATUS, SEL_MAC, SEL_INFO
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] ch;
    } reg_dec_t;

    // Channel blocks live below 0x100 at 16-byte strides; byte lanes within a word are ignored.
    function automatic reg_dec_t reg_decode(input logic [31:0] addr, input logic [4:0] ch_count);
        reg_dec_t d;
        d.sel = SEL_NONE;
        d.ch  = addr[6:4];
        if (addr[31:8] == 24'd0) begin
            if ({1'b0, addr[7:4]} < ch_count) begin
                case (addr[3:0] & 4'hC)
                    OFF_ADDR: d.sel = SEL_ADDR;
                    OFF_LEN:  d.sel = SEL_LEN;
                    OFF_CTRL: d.sel = SEL_CTRL;
                    default:  d.sel = SEL_STATUS;
                endcase
            end
        end else if ((addr & ~32'h3) == ADDR_MAC_CONFIG) begin
            d.sel = SEL_MAC;
        end else if ((addr & ~32'h3) == ADDR_INFO) begin
            d.sel = SEL_INFO;
        end
        return d;
    endfunction

endpackage

// File: rtl/axil_dma_desc_queue_if.sv
// AXI-lite register port bundle for the descriptor queue.
interface axil_dma_desc_queue_if #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 12,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
);
    logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr;
    logic [2:0]                 s_axil_awprot;
    logic                       s_axil_awvalid;
    logic                       s_axil_awready;
    logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata;
    logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb;
    logic                       s_axil_wvalid;
    logic                       s_axil_wready;
    logic [1:0]                 s_axil_bresp;
    logic                       s_axil_bvalid;
    logic                       s_axil_bready;
    logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr;
    logic [2:0]                 s_axil_arprot;
    logic                       s_axil_arvalid;
    logic                       s_axil_arready;
    logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata;
    logic [1:0]                 s_axil_rresp;
    logic                       s_axil_rvalid;
    logic                       s_axil_rready;

    modport slave (
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
               s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid,
               s_axil_rready,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
               s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );

    modport master (
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid, s_axil_wdata, s_axil_wstrb,
               s_axil_wvalid, s_axil_bready, s_axil_araddr, s_axil_arprot, s_axil_arvalid,
               s_axil_rready,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid, s_axil_arready,
               s_axil_rdata, s_axil_rresp, s_axil_rvalid
    );
endinterface

// File: rtl/axil_dma_desc_queue_fifo.sv
// Per-channel descriptor FIFO: flush wins over pop, and a pop frees room for a same-edge push.
module desc_fifo #(
    parameter int DATA_W = 48,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic                      i_flush,
    input  logic [DATA_W-1:0]         i_data,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_level,
    output logic                      o_drop
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [PW:0]       r_level;
    logic              w_push, w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == (PW+1)'(DEPTH));
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign w_push  = i_push && (!o_full || w_pop || i_flush);
    assign o_drop  = i_push && !w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= PW'(w_push);
            r_level <= (PW+1)'(w_push);
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            r_level <= r_level + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[i_flush ? PW'(0) : r_wr] <= i_data;
    end
endmodule

// File: rtl/axil_dma_desc_queue.sv
// AXI-lite programmed DMA descriptor queues: stage ADDR/LEN, push via CTRL, drain on m_axis_desc_*.
module axil_dma_desc_queue
    import axil_dma_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 12,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int CH_COUNT        = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    axil_dma_desc_queue_if.slave               s_axil,
    output logic                               mii_mode,
    output logic [CH_COUNT*AXI_ADDR_WIDTH-1:0] m_axis_desc_addr,
    output logic [CH_COUNT*LEN_WIDTH-1:0]      m_axis_desc_len,
    output logic [CH_COUNT-1:0]                m_axis_desc_valid,
    input  logic [CH_COUNT-1:0]                m_axis_desc_ready
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = AXI_ADDR_WIDTH + LEN_WIDTH;

    typedef logic [AXIL_ADDR_WIDTH-1:0] axil_addr_t;

    axil_addr_t                 w_awaddr, w_araddr;
    reg_dec_t                   w_wdec, w_rdec;
    logic                       w_wr_acc, w_rd_acc, w_unused;
    logic [AXIL_DATA_WIDTH-1:0] w_wmask, w_wdata, w_rdata;
    logic [1:0]                 w_rresp;

    logic                       r_bvalid, r_rvalid, r_mii;
    logic [1:0]                 r_bresp, r_rresp;
    logic [AXIL_DATA_WIDTH-1:0] r_rdata;
    logic [AXI_ADDR_WIDTH-1:0]  r_addr [CH_COUNT];
    logic [LEN_WIDTH-1:0]       r_len  [CH_COUNT];
    logic [CH_COUNT-1:0]        r_push, r_flush, r_ovf;
    logic [CH_COUNT-1:0]        w_full, w_empty, w_drop;
    logic [LW-1:0]              w_level [CH_COUNT];

    assign w_awaddr = s_axil.s_axil_awaddr;
    assign w_araddr = s_axil.s_axil_araddr;
    assign w_wdata  = s_axil.s_axil_wdata;
    assign w_wdec   = reg_decode(32'(w_awaddr), 5'(CH_COUNT));
    assign w_rdec   = reg_decode(32'(w_araddr), 5'(CH_COUNT));
    assign w_unused = ^{s_axil.s_axil_awprot, s_axil.s_axil_arprot};

    // Ready is a combinational grant so the handshake completes in the cycle both valids show up.
    assign w_wr_acc = !rst && s_axil.s_axil_awvalid && s_axil.s_axil_wvalid && !r_bvalid;
    assign w_rd_acc = !rst && s_axil.s_axil_arvalid && !r_rvalid;

    assign s_axil.s_axil_awready = w_wr_acc;
    assign s_axil.s_axil_wready  = w_wr_acc;
    assign s_axil.s_axil_bvalid  = r_bvalid;
    assign s_axil.s_axil_bresp   = r_bresp;
    assign s_axil.s_axil_arready = w_rd_acc;
    assign s_axil.s_axil_rvalid  = r_rvalid;
    assign s_axil.s_axil_rresp   = r_rresp;
    assign s_axil.s_axil_rdata   = r_rdata;
    assign mii_mode              = r_mii;

    always_comb begin
        w_wmask = '0;
        for (int i = 0; i < AXIL_STRB_WIDTH; i++) w_wmask[8*i +: 8] = {8{s_axil.s_axil_wstrb[i]}};
    end

    always_comb begin
        w_rdata = '0;
        w_rresp = (w_rdec.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
        if (w_rdec.sel == SEL_MAC)  w_rdata[0] = r_mii;
        if (w_rdec.sel == SEL_INFO) w_rdata = {16'd0, 8'(FIFO_DEPTH), 8'(CH_COUNT)};
        for (int c = 0; c < CH_COUNT; c++) begin
            if (w_rdec.ch == 3'(c)) begin
                case (w_rdec.sel)
                    SEL_ADDR: w_rdata = 32'(r_addr[c]);
                    SEL_LEN:  w_rdata = 32'(r_len[c]);
                    SEL_STATUS: begin
                        w_rdata[7:0]           = 8'(w_level[c]);
                        w_rdata[STAT_EMPTY_BIT] = w_empty[c];
                        w_rdata[STAT_FULL_BIT]  = w_full[c];
                        w_rdata[STAT_OVF_BIT]   = r_ovf[c];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Push/flush are registered so the queue updates on the edge after the write handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_mii    <= 1'b0;
            r_push   <= '0;
            r_flush  <= '0;
            r_ovf    <= '0;
            for (int c = 0; c < CH_COUNT; c++) begin
                r_addr[c] <= '0;
                r_len[c]  <= '0;
            end
        end else begin
            r_push  <= '0;
            r_flush <= '0;
            if (w_wr_acc) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_wdec.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
                if (w_wdec.sel == SEL_MAC && s_axil.s_axil_wstrb[0]) r_mii <= w_wdata[0];
                for (int c = 0; c < CH_COUNT; c++) begin
                    if (w_wdec.ch == 3'(c)) begin
                        case (w_wdec.sel)
                            SEL_ADDR: r_addr[c] <= AXI_ADDR_WIDTH'((32'(r_addr[c]) & ~w_wmask) | (w_wdata & w_wmask));
                            SEL_LEN:  r_len[c]  <= LEN_WIDTH'((32'(r_len[c]) & ~w_wmask) | (w_wdata & w_wmask));
                            SEL_CTRL: begin
                                r_push[c]  <= s_axil.s_axil_wstrb[0] && w_wdata[CTRL_PUSH_BIT];
                                r_flush[c] <= s_axil.s_axil_wstrb[0] && w_wdata[CTRL_FLUSH_BIT];
                            end
                            SEL_STATUS: if (s_axil.s_axil_wstrb[1] && w_wdata[STAT_OVF_BIT]) r_ovf[c] <= 1'b0;
                            default: ;
                        endcase
                    end
                end
            end else if (r_bvalid && s_axil.s_axil_bready) begin
                r_bvalid <= 1'b0;
            end
            for (int c = 0; c < CH_COUNT; c++) if (w_drop[c]) r_ovf[c] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_rd_acc) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rresp;
            r_rdata  <= w_rdata;
        end else if (r_rvalid && s_axil.s_axil_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
        logic [DW-1:0] w_head;
        desc_fifo #(.DATA_W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (r_push[g]),
            .i_pop   (m_axis_desc_ready[g]),
            .i_flush (r_flush[g]),
            .i_data  ({r_addr[g], r_len[g]}),
            .o_data  (w_head),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_level (w_level[g]),
            .o_drop  (w_drop[g])
        );
        assign m_axis_desc_addr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] = w_head[DW-1 -: AXI_ADDR_WIDTH];
        assign m_axis_desc_len[g*LEN_WIDTH +: LEN_WIDTH]            = w_head[LEN_WIDTH-1:0];
        assign m_axis_desc_valid[g]                                 = !w_empty[g];
    end
endmodule

// File: doc/axil_dma_desc_queue.md
AXIL_DMA_DESC_QUEUE -- requirements
Module: axil_dma_desc_queue

Interface
REQ-001 SHALL have parameter AXIL_DATA_WIDTH, default 32: AXI-lite data width, fixed at 32 in this generation.
REQ-002 SHALL have parameter AXIL_ADDR_WIDTH, default 12: AXI-lite address width.
REQ-003 SHALL have parameter AXIL_STRB_WIDTH, default AXIL_DATA_WIDTH/8: write strobe width.
REQ-004 SHALL have parameter AXI_ADDR_WIDTH, default 32: DMA address width, 1..32.
REQ-005 SHALL have parameter LEN_WIDTH, default 16: descriptor length width, 1..32.
REQ-006 SHALL have parameter CH_COUNT, default 2: number of DMA channels, 1..8.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4: descriptors per channel queue, a power of 2 that is at least 2.
REQ-008 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, reset); one clock; reset is synchronous and active-high.
REQ-009 SHALL have the AXI-lite slave write ports s_axil_awaddr/awprot/awvalid/awready, s_axil_wdata/wstrb/wvalid/wready and s_axil_bresp/bvalid/bready, widths per the parameters; awaddr is AXIL_ADDR_WIDTH.
REQ-010 SHALL have the AXI-lite slave read ports s_axil_araddr/arprot/arvalid/arready and s_axil_rdata/rresp/rvalid/rready.
REQ-011 SHALL have port mii_mode (out, 1): MAC MII/RGMII select.
REQ-012 SHALL have ports m_axis_desc_addr (out, CH_COUNT*AXI_ADDR_WIDTH) and m_axis_desc_len (out, CH_COUNT*LEN_WIDTH): head descriptor of each channel, channel 0 in the LSBs.
REQ-013 SHALL have ports m_axis_desc_valid (out, CH_COUNT) and m_axis_desc_ready (in, CH_COUNT): per-channel descriptor handshake.

Function
REQ-014 SHALL decode the register map as follows, all offsets byte addresses. Per channel c at base c*0x10: +0x0 ADDR (RW staging), +0x4 LEN (RW staging), +0x8 CTRL (WO: bit0 push, bit1 flush, reads 0), +0xC STATUS (bit[7:0] fill level, bit8 empty, bit9 full, bit10 overflow sticky; writing 1 to bit10 clears it). Global: 0x100 MAC_CONFIG (bit0 mii_mode), 0x104 INFO (RO: [7:0] CH_COUNT, [15:8] FIFO_DEPTH).
REQ-015 SHALL, for any unmapped address or any channel index >= CH_COUNT, complete the access with response 2'b11 (DECERR), return rdata 0 and change no state.
REQ-016 SHALL handle the write channel as follows: accept only when awvalid and wvalid are both high and bvalid is low; pulse awready and wready together for one cycle; assert bvalid on the next cycle and hold it, with bresp stable, until bready; never require bready before accepting.
REQ-017 SHALL apply wstrb per byte to the RW registers; bits above AXI_ADDR_WIDTH or LEN_WIDTH are read as 0.
REQ-018 SHALL handle the read channel as follows: accept when arvalid is high and rvalid is low; pulse arready for one cycle; register rdata and rresp; assert rvalid on the next cycle and hold it with data stable until rready.
REQ-019 SHALL permit a read and a write to proceed in the same cycle; a read of STATUS in the cycle that a push is accepted returns the pre-push value.
REQ-020 SHALL, on a CTRL push with the queue not full, enqueue {ADDR, LEN} so that it is visible on m_axis_desc_* 1 cycle after the write handshake when the queue was empty.
REQ-021 SHALL, on a push to a full queue, drop the descriptor, set overflow and still respond OKAY.
REQ-022 SHALL hold m_axis_desc_valid[c] exactly while queue c is non-empty; descriptor data is stable while valid && !ready, and valid && ready pops the head.
REQ-023 SHALL, on a push and a pop in the same cycle, leave the fill level unchanged, and this SHALL be accepted even when the queue is full.
REQ-024 SHALL, on flush, empty queue c on the next cycle, with flush taking priority over a same-cycle pop; push and flush both set in one write means flush then push, leaving fill level 1.
REQ-025 SHALL wrap the queue read/write pointers modulo FIFO_DEPTH, with the fill level computed as a log2(FIFO_DEPTH)+1-bit value.

Reset
REQ-026 SHALL, while rst is high at a clk edge, clear all queues, overflow, ADDR, LEN and mii_mode to 0 and drive awready, wready, arready, bvalid, rvalid and m_axis_desc_valid to 0, with bresp, rresp and rdata at 0.
REQ-027 SHALL discard any AXI-lite transaction in flight at reset, issuing no late bvalid or rvalid.

Structure
REQ-028 SHALL place the register offsets, CTRL/STATUS bit positions and response codes in the shared package axil_dma_pkg.
REQ-029 SHALL use one sub-module, desc_fifo (synchronous FIFO with push, pop, flush, level, full and empty), instantiated CH_COUNT times via generate.

Verification
REQ-030 SHALL cover this scenario: write ADDR0=0x1000_0000, LEN0=0x0200, CTRL0=1 -> desc_valid[0] high 1 cycle after bvalid, with addr=0x1000_0000 and len=0x0200.
REQ-031 SHALL cover this scenario: 5 pushes to channel 1 with FIFO_DEPTH=4 and ready low -> STATUS1 reads 0x604 (full, overflow, level 4), and after clearing, 0x204.
REQ-032 SHALL cover this scenario: pop and push at the same edge with the queue full -> level stays 4, overflow stays 0 and descriptor order is preserved.
REQ-033 SHALL cover this scenario: read 0x0F0 and write 0x200 -> rresp=2'b11 with rdata=0, bresp=2'b11, and no register changes.
REQ-034 SHALL cover this scenario: bready held low for 10 cycles -> bvalid and bresp stable throughout, and no second write is accepted.
REQ-035 SHALL cover this scenario: rst asserted with 3 queued descriptors and rvalid pending -> the next cycle has desc_valid=0, rvalid=0 and STATUS=0x100.
